// File: rtl/cgp_reconfig_array.sv
// Runtime-reconfigurable CGP array: ROWS x COLS grid of 4-LUT nodes with word-serial genome loading.
// Optional CGP_PARITY_EN: MSB of each config word is an even-parity bit; genome rejected on failure.
module cgp_reconfig_array #(
    parameter int unsigned N_IN        = 10,
    parameter int unsigned ROWS        = 10,
    parameter int unsigned COLS        = 10,
    parameter int unsigned LEVELS_BACK = 2,
    parameter int unsigned CFG_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    output logic             out_valid,
    output logic [ROWS-1:0]  out_data,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_last,
    output logic             cfg_done,
    output logic             cfg_err
);

    localparam int unsigned N_NODES = ROWS * COLS;
    localparam int unsigned SRC_N   = 1 + N_IN + N_NODES;
    localparam int unsigned SEL_W   = $clog2(SRC_N);
    localparam int unsigned NODE_W  = 16 + 4 * SEL_W;
    localparam int unsigned GEN_W   = N_NODES * NODE_W;
`ifdef CGP_PARITY_EN
    localparam int unsigned PAY_W   = CFG_W - 1;
`else
    localparam int unsigned PAY_W   = CFG_W;
`endif
    localparam int unsigned N_WORDS = (GEN_W + PAY_W - 1) / PAY_W;
    localparam int unsigned SH_W    = N_WORDS * PAY_W;
    localparam int unsigned CNT_W   = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCommit, StErr} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bad_q;
    logic [SH_W-1:0]    shadow_q;
    logic [SH_W-1:0]    shadow_next;
    logic [GEN_W-1:0]   active_q;
    logic [PAY_W-1:0]   payload;
    logic               par_bad;
    logic               accept;

`ifdef CGP_PARITY_EN
    assign payload = cfg_data[CFG_W-2:0];
    assign par_bad = ^cfg_data;
`else
    assign payload = cfg_data;
    assign par_bad = 1'b0;
`endif

    assign cfg_ready   = (state_q == StIdle) || (state_q == StLoad);
    assign accept      = cfg_valid && cfg_ready;
    assign shadow_next = (shadow_q >> PAY_W) | (SH_W'(payload) << (SH_W - PAY_W));

    // Each column gets its own source vector holding only the sources it may legally read, so
    // illegal references are constant 0 and no combinational loop can be formed.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [ROWS-1:0]  out;
        logic [SRC_N-1:0] src;

        assign src[0]      = 1'b0;
        assign src[N_IN:1] = in_data;

        for (genvar j = 0; j < N_NODES; j++) begin : g_src
            if ((j / ROWS) < c && (j / ROWS) + LEVELS_BACK >= c) begin : g_legal
                assign src[N_IN+1+j] = g_col[j/ROWS].out[j%ROWS];
            end else begin : g_illegal
                assign src[N_IN+1+j] = 1'b0;
            end
        end

        for (genvar r = 0; r < ROWS; r++) begin : g_node
            localparam int unsigned NI = c * ROWS + r;
            logic [15:0] lut_init;
            logic [3:0]  idx;

            assign lut_init = active_q[NI*NODE_W +: 16];

            for (genvar k = 0; k < 4; k++) begin : g_in
                logic [SEL_W-1:0] sel;
                assign sel    = active_q[NI*NODE_W+16+k*SEL_W +: SEL_W];
                // Selectors past the source space shift the one-hot out and read 0.
                assign idx[k] = |(src & (SRC_N'(1) << sel));
            end

            assign out[r] = lut_init[idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= g_col[COLS-1].out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shadow_q <= shadow_next;
                        cnt_q    <= CNT_W'(1);
                        bad_q    <= par_bad;
                        if (cfg_last) begin
                            if (N_WORDS == 1 && !par_bad) begin
                                state_q  <= StCommit;
                                cfg_done <= 1'b1;
                            end else begin
                                state_q <= StErr;
                                cfg_err <= 1'b1;
                            end
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        shadow_q <= shadow_next;
                        bad_q    <= bad_q | par_bad;
                        if (cfg_last) begin
                            if (cnt_q == CNT_W'(N_WORDS - 1) && !(bad_q || par_bad)) begin
                                state_q  <= StCommit;
                                cfg_done <= 1'b1;
                            end else begin
                                state_q <= StErr;
                                cfg_err <= 1'b1;
                            end
                        end else if (cnt_q == CNT_W'(N_WORDS)) begin
                            state_q <= StErr;
                            cfg_err <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StCommit: begin
                    active_q <= shadow_q[GEN_W-1:0];
                    cnt_q    <= '0;
                    state_q  <= StIdle;
                end
                StErr: begin
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cgp_reconfig_array.sv
// Self-checking bench for cgp_reconfig_array (2x2 array, 2 inputs) with a genome-level model.
// Exercises the CGP_PARITY_EN path when that macro is defined.
module tb_cgp_reconfig_array;

    localparam int N_IN   = 2;
    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int LB     = 2;
    localparam int CFG_W  = 32;
    localparam int NN     = ROWS * COLS;
    localparam int SEL_W  = $clog2(1 + N_IN + NN);
    localparam int NODE_W = 16 + 4 * SEL_W;
    localparam int G      = NN * NODE_W;
`ifdef CGP_PARITY_EN
    localparam int PW     = CFG_W - 1;
`else
    localparam int PW     = CFG_W;
`endif
    localparam int NW     = (G + PW - 1) / PW;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [N_IN-1:0]  in_data;
    logic             out_valid;
    logic [ROWS-1:0]  out_data;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic             cfg_last;
    logic             cfg_done;
    logic             cfg_err;

    cgp_reconfig_array #(
        .N_IN        (N_IN),
        .ROWS        (ROWS),
        .COLS        (COLS),
        .LEVELS_BACK (LB),
        .CFG_W       (CFG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_last  (cfg_last),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_seen = 0;
    int err_seen  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Evaluate the genome by walking nodes in index order, applying the source rules directly.
    function automatic logic [ROWS-1:0] model_eval(input logic [G-1:0] g,
                                                   input logic [N_IN-1:0] x);
        logic            val [NN];
        logic [ROWS-1:0] res;
        for (int i = 0; i < NN; i++) begin
            int          c;
            logic [15:0] init;
            logic [3:0]  idx;
            c    = i / ROWS;
            init = g[i*NODE_W +: 16];
            for (int k = 0; k < 4; k++) begin
                int s;
                int j;
                s      = int'(g[i*NODE_W+16+k*SEL_W +: SEL_W]);
                idx[k] = 1'b0;
                if (s >= 1 && s <= N_IN) begin
                    idx[k] = x[s-1];
                end else if (s > N_IN) begin
                    j = s - N_IN - 1;
                    if (j < NN && (j / ROWS) >= c - LB && (j / ROWS) <= c - 1) idx[k] = val[j];
                end
            end
            val[i] = init[idx];
        end
        for (int r = 0; r < ROWS; r++) res[r] = val[(COLS-1)*ROWS + r];
        return res;
    endfunction

    function automatic logic [G-1:0] set_node(input logic [G-1:0] g, input int i,
                                              input logic [15:0] init, input int s0,
                                              input int s1, input int s2, input int s3);
        logic [G-1:0] r;
        r = g;
        r[i*NODE_W +: 16]            = init;
        r[i*NODE_W+16 +: SEL_W]         = SEL_W'(s0);
        r[i*NODE_W+16+SEL_W +: SEL_W]   = SEL_W'(s1);
        r[i*NODE_W+16+2*SEL_W +: SEL_W] = SEL_W'(s2);
        r[i*NODE_W+16+3*SEL_W +: SEL_W] = SEL_W'(s3);
        return r;
    endfunction

    function automatic logic [CFG_W-1:0] word_of(input logic [G-1:0] g, input int w);
        logic [NW*PW-1:0] pad;
        logic [PW-1:0]    p;
        pad         = '0;
        pad[G-1:0]  = g;
        if (w < NW) p = pad[w*PW +: PW];
        else        p = PW'(32'h5A5A_1234 + w);
`ifdef CGP_PARITY_EN
        return {^p, p};
`else
        return p;
`endif
    endfunction

    // Genome-level model: collects words into the genome image and decides commit/reject.
    logic [G-1:0]     m_active = '0;
    logic [NW*PW-1:0] m_buf    = '0;
    int               m_cnt    = 0;
    bit               m_bad    = 1'b0;
    int               m_phase  = 0;  // 0 accepting, 1 commit cycle, 2 reject cycle
    bit               exp_ov   = 1'b0;
    logic [ROWS-1:0]  exp_od   = '0;
    bit               exp_done = 1'b0;
    bit               exp_err  = 1'b0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_active = '0;
            m_cnt    = 0;
            m_bad    = 1'b0;
            m_phase  = 0;
            exp_ov   = 1'b0;
            exp_od   = '0;
            exp_done = 1'b0;
            exp_err  = 1'b0;
        end else begin
            exp_ov = in_valid;
            if (in_valid) exp_od = model_eval(m_active, in_data);
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (m_phase == 1) begin
                m_active = m_buf[G-1:0];
                m_phase  = 0;
                m_cnt    = 0;
            end else if (m_phase == 2) begin
                m_phase = 0;
                m_cnt   = 0;
            end else if (cfg_valid) begin
                if (m_cnt == 0) m_bad = 1'b0;
`ifdef CGP_PARITY_EN
                if (^cfg_data) m_bad = 1'b1;
`endif
                if (m_cnt < NW) m_buf[m_cnt*PW +: PW] = cfg_data[PW-1:0];
                m_cnt++;
                if (cfg_last) begin
                    if (m_cnt == NW && !m_bad) begin
                        m_phase  = 1;
                        exp_done = 1'b1;
                    end else begin
                        m_phase = 2;
                        exp_err = 1'b1;
                    end
                end else if (m_cnt > NW) begin
                    m_phase = 2;
                    exp_err = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            check("out_valid", out_valid, exp_ov);
            check("out_data", out_data, exp_od);
            check("cfg_ready", cfg_ready, m_phase == 0);
            check("cfg_done", cfg_done, exp_done);
            check("cfg_err", cfg_err, exp_err);
            if (cfg_done) done_seen++;
            if (cfg_err) err_seen++;
        end
    end

    task automatic send(input logic [G-1:0] g, input int n, input int last_at, input int gap,
                        input int flip_w);
        for (int w = 0; w < n; w++) begin
            int t;
            t = 0;
            while (!cfg_ready && t < 20) begin
                step();
                t++;
            end
            check("send_ready", cfg_ready, 1);
            cfg_valid = 1'b1;
            cfg_data  = word_of(g, w);
            if (w == flip_w) cfg_data[3] = ~cfg_data[3];
            cfg_last  = (w == last_at);
            step();
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            if (w != n - 1) repeat (gap) step();
        end
    endtask

    task automatic eval_check(input string name, input logic [N_IN-1:0] x,
                              input logic [ROWS-1:0] exp);
        in_valid = 1'b1;
        in_data  = x;
        step();
        check(name, out_data, exp);
        check({name, "_valid"}, out_valid, 1);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
        $fatal(1);
    end

    logic [G-1:0] g_a, g_c, g_d, g_e, g_f;
    int d0;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = '1;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        cfg_last  = 1'b0;

        g_a = set_node('0, 0, 16'h8888, 1, 2, 0, 0);
        g_a = set_node(g_a, 2, 16'hAAAA, 3, 0, 0, 0);
        g_c = set_node(g_a, 2, 16'h5555, 3, 0, 0, 0);
        g_d = set_node(g_a, 2, 16'hAAAA, 1 + N_IN + NN, 0, 0, 0);
        g_e = set_node('0, 1, 16'hAAAA, 2, 0, 0, 0);
        g_e = set_node(g_e, 2, 16'h5555, N_IN + 1 + 3, 0, 0, 0);
        g_e = set_node(g_e, 3, 16'hAAAA, N_IN + 1 + 1, 0, 0, 0);
        g_f = set_node(g_a, 2, 16'h5555, 3, 0, 0, 0);
        g_f = set_node(g_f, 3, 16'hAAAA, 1, 0, 0, 0);

        // Reset values, then one evaluation against the all-zero genome
        repeat (3) step();
        rst = 1'b0;
        check("t1_ready", cfg_ready, 1);
        check("t1_out_valid_rst", out_valid, 0);
        check("t1_out_data_rst", out_data, 0);
        step();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 0);
        in_valid = 1'b0;

        // AND of the inputs buffered to out_data[0]
        d0 = done_seen;
        send(g_a, NW, NW - 1, 0, -1);
        check("t2_done", cfg_done, 1);
        step();
        eval_check("t2_in11", 2'b11, 2'b01);
        eval_check("t2_in10", 2'b10, 2'b00);
        check("t2_done_once", done_seen - d0, 1);

        // Early cfg_last rejects, active genome untouched
        send(g_c, 3, 2, 0, -1);
        check("t3_err", cfg_err, 1);
        check("t3_no_done", cfg_done, 0);
        step();
        eval_check("t3_in11", 2'b11, 2'b01);

        // One word too many without cfg_last rejects
        send(g_c, NW + 1, -1, 0, -1);
        check("t3b_err", cfg_err, 1);
        step();
        eval_check("t3b_in11", 2'b11, 2'b01);

        // Out-of-range selector reads 0
        send(g_d, NW, NW - 1, 0, -1);
        step();
        eval_check("t4_in11", 2'b11, 2'b00);
        eval_check("t4_in01", 2'b01, 2'b00);

        // Same-column reference reads 0; node3 buffers node1 = in1
        send(g_e, NW, NW - 1, 0, -1);
        step();
        eval_check("t4b_in10", 2'b10, 2'b11);
        eval_check("t4b_in01", 2'b01, 2'b01);

        // Continuous evaluation across commit, with gaps between config words
        in_valid = 1'b1;
        in_data  = 2'b11;
        send(g_f, NW, NW - 1, 1, -1);
        check("t5_done", cfg_done, 1);
        check("t5_old_a", out_data, 2'b11);
        step();
        check("t5_old_commit", out_data, 2'b11);
        check("t5_no_gap", out_valid, 1);
        step();
        check("t5_new", out_data, 2'b10);
        in_valid = 1'b0;

        // Reset mid-load, then a clean load
        send(g_e, 2, -1, 0, -1);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("t6_ready", cfg_ready, 1);
        check("t6_out_rst", out_data, 0);
        eval_check("t6_zero", 2'b11, 2'b00);
        send(g_a, NW, NW - 1, 0, -1);
        check("t6_done", cfg_done, 1);
        step();
        eval_check("t6_in11", 2'b11, 2'b01);
`ifdef CGP_PARITY_EN
        send(g_d, NW, NW - 1, 0, 0);
        check("t6_par_err", cfg_err, 1);
        check("t6_par_no_done", cfg_done, 0);
        step();
        eval_check("t6_par_keep", 2'b11, 2'b01);
`endif
        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
